// File: rtl/ahb_slave_ram_pkg.sv
// Shared AHB encodings, FSM state type and lane-merge helper for the AHB slave RAM.
package ahb_slave_ram_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } state_e;

    function automatic logic trans_active(input logic [1:0] trans);
        return (trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ);
    endfunction

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ahb_byte_lanes.sv
// Little-endian byte-lane enables for an AHB transfer, plus a misalignment/illegal-size flag.
module ahb_byte_lanes
    import ahb_slave_ram_pkg::*;
(
    input  logic [1:0] addr,
    input  logic [2:0] size,
    output logic [3:0] lanes,
    output logic       misaligned
);

    // Decode size and low address bits into lane enables.
    always_comb begin
        lanes      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            HSIZE_BYTE: begin
                lanes = 4'b0001 << addr;
            end
            HSIZE_HALF: begin
                if (addr[0]) begin
                    misaligned = 1'b1;
                end else if (addr[1]) begin
                    lanes = 4'b1100;
                end else begin
                    lanes = 4'b0011;
                end
            end
            HSIZE_WORD: begin
                if (addr != 2'b00) begin
                    misaligned = 1'b1;
                end else begin
                    lanes = 4'b1111;
                end
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ahb_slave_ram.sv
// AHB-Lite slave RAM with programmable wait states, two-cycle ERROR response,
// byte-lane writes and write-to-read forwarding for back-to-back transfers.
module ahb_slave_ram
    import ahb_slave_ram_pkg::*;
#(
    parameter int ADDR_WORDS  = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int          AW        = $clog2(ADDR_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(ADDR_WORDS * 4);
    localparam logic [1:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_e        state_r, state_nx_s;
    logic [1:0]    cnt_r, cnt_nx_s;
    logic          comp_r, comp_nx_s;
    logic [AW-1:0] addr_r;
    logic          write_r;
    logic [3:0]    lanes_r;
    logic [31:0]   hrdata_r;
    logic          hreadyout_r, hreadyout_nx_s;
    logic          hresp_r, hresp_nx_s;

    logic [31:0]   mem_r [ADDR_WORDS];

    logic          accept_s;
    logic          take_s;
    logic          err_s;
    logic          misaligned_s;
    logic [3:0]    lanes_s;
    logic          commit_s;
    logic          rd_load_s;
    logic [AW-1:0] rd_idx_s;
    logic [31:0]   fwd_s;

    ahb_byte_lanes u_lanes (
        .addr       (HADDR[1:0]),
        .size       (HSIZE),
        .lanes      (lanes_s),
        .misaligned (misaligned_s)
    );

    assign accept_s = HSEL & trans_active(HTRANS) & HREADY;
    assign err_s    = misaligned_s | (HADDR >= MEM_BYTES);
    assign commit_s = comp_r & write_r & ~reset;

    // A pipelined read must see the data of the write completing on the same edge.
    assign rd_idx_s = take_s ? HADDR[AW+1:2] : addr_r;
    assign fwd_s    = (commit_s && (addr_r == rd_idx_s)) ?
                      merge_lanes(mem_r[rd_idx_s], HWDATA, lanes_r) : mem_r[rd_idx_s];

    // Next-state, wait counter and completion-cycle decode.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        comp_nx_s  = 1'b0;
        take_s     = 1'b0;
        case (state_r)
            IDLE, ERR2: begin
                if (accept_s) begin
                    take_s = 1'b1;
                    if (err_s) begin
                        state_nx_s = ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_nx_s = IDLE;
                        comp_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = WAIT;
                        cnt_nx_s   = WAIT_LOAD;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 2'd0) begin
                    state_nx_s = IDLE;
                    comp_nx_s  = 1'b1;
                end else begin
                    cnt_nx_s = cnt_r - 2'd1;
                end
            end
            ERR1: begin
                state_nx_s = ERR2;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = 2'd0;
            end
        endcase
        hreadyout_nx_s = (state_nx_s != WAIT) && (state_nx_s != ERR1);
        hresp_nx_s     = ((state_nx_s == ERR1) || (state_nx_s == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
        rd_load_s      = comp_nx_s & ~(take_s ? HWRITE : write_r);
    end

    // Control state, captured address phase and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 2'd0;
            comp_r      <= 1'b0;
            addr_r      <= '0;
            write_r     <= 1'b0;
            lanes_r     <= 4'b0000;
            hrdata_r    <= 32'h0000_0000;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            comp_r      <= comp_nx_s;
            hreadyout_r <= hreadyout_nx_s;
            hresp_r     <= hresp_nx_s;
            if (take_s) begin
                addr_r  <= HADDR[AW+1:2];
                write_r <= HWRITE;
                lanes_r <= lanes_s;
            end
            if (rd_load_s) begin
                hrdata_r <= fwd_s;
            end
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[addr_r] <= merge_lanes(mem_r[addr_r], HWDATA, lanes_r);
        end
    end

    assign HRDATA    = hrdata_r;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

endmodule

// File: tb/tb_ahb_slave_ram.sv
// Directed bench: table of single transfers on a 1-wait-state slave, plus hand-built
// sequences for error timing, reset abort, idle traffic, HREADY gating and 0-wait pipelining.
module tb_ahb_slave_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel1, hsel0;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hold;
    logic [31:0] hrdata1, hrdata0;
    logic        hreadyout1, hreadyout0, hresp1, hresp0;
    logic        hready1, hready0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hready1 = hreadyout1 & ~hold;
    assign hready0 = hreadyout0;

    ahb_slave_ram #(.ADDR_WORDS(64), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready1),
        .HRDATA(hrdata1), .HREADYOUT(hreadyout1), .HRESP(hresp1)
    );

    ahb_slave_ram #(.ADDR_WORDS(64), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
        .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_resp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        hsel1  = 1'b0;
        hsel0  = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        haddr  = 32'h0;
        hsize  = 3'd2;
    endtask

    // One transfer on the 1-wait slave; returns low-HREADYOUT cycle count and completion values.
    task automatic xfer1(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic resp, output int waits);
        @(negedge clk);
        hsel1  = 1'b1;
        htrans = 2'b10;
        hwrite = wr;
        haddr  = addr;
        hsize  = size;
        @(negedge clk);
        bus_idle();
        hwdata = wdata;
        waits  = 0;
        while (hreadyout1 !== 1'b1 && waits < 8) begin
            waits++;
            @(negedge clk);
        end
        rdata = hrdata1;
        resp  = hresp1;
    endtask

    // Write followed immediately by a pipelined read on the 0-wait slave.
    task automatic pipe0(input string tag, input logic [31:0] waddr, input logic [2:0] wsize,
                         input logic [31:0] wdata, input logic [31:0] raddr,
                         input logic [31:0] exp);
        @(negedge clk);
        hsel0  = 1'b1;
        htrans = 2'b10;
        hwrite = 1'b1;
        haddr  = waddr;
        hsize  = wsize;
        @(negedge clk);
        chk({tag, "_wready"}, 32'(hreadyout0), 32'd1);
        hwdata = wdata;
        hwrite = 1'b0;
        haddr  = raddr;
        hsize  = 3'd2;
        @(negedge clk);
        chk({tag, "_rready"}, 32'(hreadyout0), 32'd1);
        chk({tag, "_rdata"}, hrdata0, exp);
        bus_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        rs;
        int          wt;

        vecs[0]  = '{1'b1, 32'h10,  3'd2, 32'h12345678, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h12345678, 1'b0};
        vecs[2]  = '{1'b1, 32'h11,  3'd0, 32'h0000AB00, 32'h0,        1'b0};
        vecs[3]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h1234AB78, 1'b0};
        vecs[4]  = '{1'b1, 32'h12,  3'd1, 32'hCAFE0000, 32'h0,        1'b0};
        vecs[5]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'hCAFEAB78, 1'b0};
        vecs[6]  = '{1'b1, 32'h13,  3'd0, 32'h11000000, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h11FEAB78, 1'b0};
        vecs[8]  = '{1'b1, 32'h20,  3'd2, 32'h0BADF00D, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h22,  3'd2, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{1'b1, 32'h22,  3'd2, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[11] = '{1'b1, 32'h11,  3'd1, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 32'h10,  3'd3, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b1, 32'h100, 3'd2, 32'hFFFFFFFF, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 32'h20,  3'd2, 32'h0,        32'h0BADF00D, 1'b0};
        vecs[15] = '{1'b0, 32'h10,  3'd2, 32'h0,        32'h11FEAB78, 1'b0};
        vecs[16] = '{1'b1, 32'hFC,  3'd2, 32'hA5A55A5A, 32'h0,        1'b0};
        vecs[17] = '{1'b0, 32'hFC,  3'd2, 32'h0,        32'hA5A55A5A, 1'b0};

        reset  = 1'b1;
        hold   = 1'b0;
        hwdata = 32'h0;
        bus_idle();
        repeat (3) @(negedge clk);
        chk("rst_ready1", 32'(hreadyout1), 32'd1);
        chk("rst_resp1",  32'(hresp1),     32'd0);
        chk("rst_rdata1", hrdata1,         32'h0);
        chk("rst_ready0", 32'(hreadyout0), 32'd1);
        chk("rst_resp0",  32'(hresp0),     32'd0);
        chk("rst_rdata0", hrdata0,         32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            xfer1(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rs, wt);
            chk($sformatf("vec%0d_waits", i), 32'(wt), 32'd1);
            chk($sformatf("vec%0d_resp", i), 32'(rs), 32'(vecs[i].exp_resp));
            if (!vecs[i].wr && !vecs[i].exp_resp) begin
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        // Two-cycle error response timing.
        @(negedge clk);
        hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h22; hsize = 3'd2;
        @(negedge clk);
        bus_idle();
        chk("err1_ready", 32'(hreadyout1), 32'd0);
        chk("err1_resp",  32'(hresp1),     32'd1);
        @(negedge clk);
        chk("err2_ready", 32'(hreadyout1), 32'd1);
        chk("err2_resp",  32'(hresp1),     32'd1);
        @(negedge clk);
        chk("post_err_ready", 32'(hreadyout1), 32'd1);
        chk("post_err_resp",  32'(hresp1),     32'd0);

        // Reset during the wait state of a write aborts it.
        xfer1(1'b1, 32'h30, 3'd2, 32'h0000AAAA, rd, rs, wt);
        @(negedge clk);
        hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        @(negedge clk);
        bus_idle();
        hwdata = 32'h00000055;
        chk("abort_wait_ready", 32'(hreadyout1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(hreadyout1), 32'd1);
        chk("abort_resp",  32'(hresp1),     32'd0);
        chk("abort_rdata", hrdata1,         32'h0);
        reset = 1'b0;
        xfer1(1'b0, 32'h30, 3'd2, 32'h0, rd, rs, wt);
        chk("abort_mem", rd, 32'h0000AAAA);

        // IDLE and BUSY transfers while selected: no wait, no error, no write.
        @(negedge clk);
        hsel1 = 1'b1; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2; hwdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            htrans = (i == 2) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk($sformatf("idle%0d_ready", i), 32'(hreadyout1), 32'd1);
            chk($sformatf("idle%0d_resp", i),  32'(hresp1),     32'd0);
        end
        bus_idle();
        xfer1(1'b0, 32'h10, 3'd2, 32'h0, rd, rs, wt);
        chk("idle_mem", rd, 32'h11FEAB78);

        // Address phase with HREADY low is ignored.
        @(negedge clk);
        hold = 1'b1;
        hsel1 = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        @(negedge clk);
        bus_idle();
        hold = 1'b0;
        chk("hready_low_ready", 32'(hreadyout1), 32'd1);
        xfer1(1'b0, 32'h10, 3'd2, 32'h0, rd, rs, wt);
        chk("hready_low_mem", rd, 32'h11FEAB78);

        // Zero-wait slave: write with read pipelined behind it, including partial merges.
        pipe0("b2b_word", 32'h20, 3'd2, 32'hDEADBEEF, 32'h20, 32'hDEADBEEF);
        pipe0("b2b_byte", 32'h21, 3'd0, 32'h00001100, 32'h20, 32'hDEAD11EF);
        pipe0("b2b_half", 32'h22, 3'd1, 32'h77660000, 32'h20, 32'h776611EF);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_ram.md
AHB_SLAVE_RAM -- requirements
Module: ahb_slave_ram

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 64, giving the number of 32-bit words stored (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving the wait cycles inserted per transfer; legal values are 0..3.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 HSEL  input  1  slave select.
REQ-006 HADDR  input  32  byte address.
REQ-007 HTRANS  input  2  transfer type; bit 1 set means NONSEQ or SEQ.
REQ-008 HWRITE  input  1  1 = write.
REQ-009 HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
REQ-010 HWDATA  input  32  write data, valid in the data phase.
REQ-011 HREADY  input  1  bus-wide ready; qualifies the address phase.
REQ-012 HRDATA  output  32  read data.
REQ-013 HREADYOUT  output  1  slave ready.
REQ-014 HRESP  output  1  0 = OKAY, 1 = ERROR.

Function
REQ-015 The block SHALL accept an address phase only on a cycle where HSEL & HTRANS[1] & HREADY is true; it SHALL register HADDR, HWRITE and HSIZE on that edge.
REQ-016 The FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
- An accepted transfer goes to WAIT with the wait counter loaded to WAIT_STATES-1, or stays in IDLE (data phase completes in the next cycle) if WAIT_STATES=0.
REQ-017 In WAIT, HREADYOUT SHALL be 0, and the counter SHALL decrement each cycle; at 0 the next cycle is the completion cycle with HREADYOUT=1.
REQ-018 Data-phase latency SHALL be exactly WAIT_STATES+1 cycles after the address-phase edge.
REQ-019 The following transfers SHALL be errors: HSIZE>2, a halfword with HADDR[0]=1, a word with HADDR[1:0]!=0, or an address at or beyond 4*ADDR_WORDS.
REQ-020 An error SHALL skip wait states and use a two-cycle response:
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
- Then return to IDLE.
- Memory SHALL NOT be modified.
REQ-021 Writes SHALL commit on the completion-cycle edge using HWDATA with byte-lane enables derived from the registered HADDR[1:0] and HSIZE (little-endian: byte lane n = HADDR[1:0]); unselected lanes SHALL be unchanged.
REQ-022 Reads SHALL return the full 32-bit word on HRDATA during the completion cycle; HRDATA outside a read completion cycle SHALL hold its last value.
REQ-023 A new address phase accepted during a completion cycle SHALL be taken with no bubble (back-to-back pipelining).
REQ-024 A read whose address phase coincides with the completion edge of a write to the same word SHALL return the merged new data (forwarding), including partial-lane merges.
REQ-025 IDLE or BUSY transfers (HTRANS[1]=0), or HSEL=0, SHALL get a zero-wait OKAY response and cause no state change.
REQ-026 Address-phase inputs presented while HREADY=0 SHALL be ignored.

Reset
REQ-027 On reset the FSM SHALL enter IDLE with HREADYOUT=1, HRESP=0, HRDATA=0, the wait counter at 0, and any pending transfer dropped.
REQ-028 Reset asserted mid-transfer (WAIT or ERR1) SHALL abort the transfer with no memory write; memory contents are not reset.

Structure
REQ-029 A shared package SHALL hold the HTRANS and HSIZE encodings, the HRESP codes and the FSM state enum.
REQ-030 Byte-lane enable generation SHALL be one sub-module, ahb_byte_lanes (inputs addr[1:0] and size; outputs lane enables and a misaligned flag).

Verification
REQ-031 Reset then word write 0x12345678 to 0x10, then read 0x10 with WAIT_STATES=1 -> one HREADYOUT=0 cycle per transfer; read returns 0x12345678.
REQ-032 Byte write 0xAB to 0x11 over 0x12345678 -> subsequent read of 0x10 returns 0x1234AB78.
REQ-033 Back-to-back write 0xDEADBEEF to 0x20 with the read of 0x20 pipelined behind it, WAIT_STATES=0 -> no stall; read returns 0xDEADBEEF.
REQ-034 Word read at 0x22 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged.
REQ-035 Reset asserted during WAIT of a write of 0x55 to 0x30 -> IDLE next cycle; read of 0x30 returns the prior value.
REQ-036 HSEL=1, HTRANS=IDLE for 5 cycles -> HREADYOUT stays 1, HRESP stays 0, no memory change.
